// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: 64-bit ALU, ZF/SF/OF condition-code register and
// jXX/cmovXX condition evaluation, all registered behind a valid/stall handshake.
module execute_cc_stage #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned STACK_STEP = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic             stall_i,
    input  logic [3:0]       icode_i,
    input  logic [3:0]       ifun_i,
    input  logic [WIDTH-1:0] val_a_i,
    input  logic [WIDTH-1:0] val_b_i,
    input  logic [WIDTH-1:0] val_c_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] val_e_o,
    output logic             cnd_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o,
    output logic             err_o
);

    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IIrmov = 4'h3;
    localparam logic [3:0] IRmmov = 4'h4;
    localparam logic [3:0] IMrmov = 4'h5;
    localparam logic [3:0] IOpq   = 4'h6;
    localparam logic [3:0] IJxx   = 4'h7;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;
    localparam logic [3:0] IPush  = 4'hA;
    localparam logic [3:0] IPop   = 4'hB;

    localparam logic [1:0] FnAdd = 2'd0;
    localparam logic [1:0] FnSub = 2'd1;
    localparam logic [1:0] FnAnd = 2'd2;
    localparam logic [1:0] FnXor = 2'd3;

    localparam logic [WIDTH-1:0] StepPos = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] StepNeg = WIDTH'(0) - StepPos;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] val_e_q, val_e_d;
    logic             cnd_q, cnd_d;
    logic             err_q, err_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic [1:0]       alu_fn;
    logic             use_alu;
    logic             cc_we;
    logic             alu_of;
    logic             cond_true;
    logic             cond_legal;
    logic             exe_cnd;
    logic             exe_err;

    // Evaluate jXX/cmovXX condition against the flags held before this edge.
    always_comb begin
        cond_true  = 1'b0;
        cond_legal = 1'b1;
        unique case (ifun_i)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = (sf_q ^ of_q) | zf_q;
            4'd2:    cond_true = sf_q ^ of_q;
            4'd3:    cond_true = zf_q;
            4'd4:    cond_true = ~zf_q;
            4'd5:    cond_true = ~(sf_q ^ of_q);
            4'd6:    cond_true = ~(sf_q ^ of_q) & ~zf_q;
            default: cond_legal = 1'b0;
        endcase
    end

    // Decode icode into ALU operands, function and side outputs.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fn  = FnAdd;
        use_alu = 1'b0;
        cc_we   = 1'b0;
        exe_cnd = 1'b0;
        exe_err = 1'b0;
        case (icode_i)
            ICmov: begin
                alu_a   = val_a_i;
                use_alu = 1'b1;
                exe_cnd = cond_legal & cond_true;
                exe_err = ~cond_legal;
            end
            IIrmov: begin
                alu_a   = val_c_i;
                use_alu = 1'b1;
            end
            IRmmov, IMrmov: begin
                alu_a   = val_c_i;
                alu_b   = val_b_i;
                use_alu = 1'b1;
            end
            IOpq: begin
                if (ifun_i <= 4'd3) begin
                    alu_a   = val_a_i;
                    alu_b   = val_b_i;
                    alu_fn  = ifun_i[1:0];
                    use_alu = 1'b1;
                    cc_we   = 1'b1;
                end else begin
                    exe_err = 1'b1;
                end
            end
            IJxx: begin
                exe_cnd = cond_legal & cond_true;
                exe_err = ~cond_legal;
            end
            ICall, IPush: begin
                alu_a   = StepNeg;
                alu_b   = val_b_i;
                use_alu = 1'b1;
            end
            IRet, IPop: begin
                alu_a   = StepPos;
                alu_b   = val_b_i;
                use_alu = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU datapath; subtraction is aluB - aluA so subq rA,rB gives rB - rA.
    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        unique case (alu_fn)
            FnAdd: begin
                alu_r  = alu_b + alu_a;
                alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                         (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
            end
            FnSub: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_b[WIDTH-1] != alu_a[WIDTH-1]) &&
                         (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
            end
            FnAnd: alu_r = alu_b & alu_a;
            FnXor: alu_r = alu_b ^ alu_a;
            default: ;
        endcase
    end

    // Next-state: accept, bubble, or hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        val_e_d     = val_e_q;
        cnd_d       = cnd_q;
        err_d       = err_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
        if (!stall_i) begin
            out_valid_d = in_valid_i;
            if (in_valid_i) begin
                val_e_d = use_alu ? alu_r : '0;
                cnd_d   = exe_cnd;
                err_d   = exe_err;
                if (cc_we) begin
                    zf_d = (alu_r == '0);
                    sf_d = alu_r[WIDTH-1];
                    of_d = alu_of;
                end
            end else begin
                cnd_d = 1'b0;
                err_d = 1'b0;
            end
        end
    end

    // State registers; synchronous reset overrides stall and in_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            val_e_q     <= val_e_d;
            cnd_q       <= cnd_d;
            err_q       <= err_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign val_e_o     = val_e_q;
    assign cnd_o       = cnd_q;
    assign err_o       = err_q;
    assign zf_o        = zf_q;
    assign sf_o        = sf_q;
    assign of_o        = of_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Bench for execute_cc_stage: directed plan steps, then random traffic, all
// checked against a behavioural Y86 execute model.
module tb_execute_cc_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [3:0]  ifun = 4'h0;
    logic [63:0] val_a = '0;
    logic [63:0] val_b = '0;
    logic [63:0] val_c = '0;
    logic        out_valid;
    logic [63:0] val_e;
    logic        cnd, zf, sf, of, err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [63:0] m_vale = '0;
    logic        m_cnd = 1'b0, m_err = 1'b0;
    logic        m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    execute_cc_stage #(
        .WIDTH      (64),
        .STACK_STEP (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .stall_i     (stall),
        .icode_i     (icode),
        .ifun_i      (ifun),
        .val_a_i     (val_a),
        .val_b_i     (val_b),
        .val_c_i     (val_c),
        .out_valid_o (out_valid),
        .val_e_o     (val_e),
        .cnd_o       (cnd),
        .zf_o        (zf),
        .sf_o        (sf),
        .of_o        (of),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Branch condition from Y86 semantics: less-than is sign differing from overflow.
    function automatic logic cond_holds(input logic [3:0] f, input logic z, input logic s,
                                        input logic o);
        logic lt;
        lt = (s != o);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return lt || z;
            4'd2:    return lt;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !lt;
            4'd6:    return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Model one edge given the inputs presented for it.
    task automatic model_edge();
        logic signed [64:0] wide;
        logic [63:0]        r;
        if (rst) begin
            m_valid = 0; m_vale = '0; m_cnd = 0; m_err = 0;
            m_zf = 1; m_sf = 0; m_of = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_cnd   = 0;
            m_err   = 0;
            if (in_valid) begin
                m_vale = '0;
                case (icode)
                    4'h2: begin
                        m_vale = val_a;
                        m_cnd  = cond_holds(ifun, m_zf, m_sf, m_of);
                        m_err  = (ifun > 6);
                    end
                    4'h3: m_vale = val_c;
                    4'h4, 4'h5: m_vale = val_c + val_b;
                    4'h6: begin
                        if (ifun > 3) begin
                            m_err = 1;
                        end else begin
                            case (ifun)
                                4'd0: begin
                                    wide = $signed({val_b[63], val_b}) + $signed({val_a[63], val_a});
                                    r = wide[63:0];
                                    m_of = (wide[64] != wide[63]);
                                end
                                4'd1: begin
                                    wide = $signed({val_b[63], val_b}) - $signed({val_a[63], val_a});
                                    r = wide[63:0];
                                    m_of = (wide[64] != wide[63]);
                                end
                                4'd2: begin r = val_b & val_a; m_of = 0; end
                                default: begin r = val_b ^ val_a; m_of = 0; end
                            endcase
                            m_vale = r;
                            m_zf = (r == 64'd0);
                            m_sf = r[63];
                        end
                    end
                    4'h7: begin
                        m_cnd = cond_holds(ifun, m_zf, m_sf, m_of);
                        m_err = (ifun > 6);
                    end
                    4'h8, 4'hA: m_vale = val_b - 64'd8;
                    4'h9, 4'hB: m_vale = val_b + 64'd8;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".valE"},      val_e,          m_vale);
        check({tag, ".cnd"},       64'(cnd),       64'(m_cnd));
        check({tag, ".err"},       64'(err),       64'(m_err));
        check({tag, ".zf"},        64'(zf),        64'(m_zf));
        check({tag, ".sf"},        64'(sf),        64'(m_sf));
        check({tag, ".of"},        64'(of),        64'(m_of));
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic v,
                        input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        rst = r; stall = s; in_valid = v; icode = ic; ifun = fn;
        val_a = a; val_b = b; val_c = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'd0;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [3:0]  ic, fn;
        logic        r, s, v;

        // Reset while stalled with a valid instruction present
        step("rst0", 1, 1, 1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        step("rst1", 1, 1, 1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.zf", 64'(zf), 64'd1);

        // subq 5,5 -> zero
        step("sub_eq", 0, 0, 1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        check("sub_eq.valE", val_e, 64'd0);
        check("sub_eq.valid", 64'(out_valid), 64'd1);

        // subq 1 from most-negative -> overflow to max positive
        step("sub_of", 0, 0, 1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        check("sub_of.valE", val_e, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_of.of", 64'(of), 64'd1);
        step("jl", 0, 0, 1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        check("jl.cnd", 64'(cnd), 64'd1);
        step("jne", 0, 0, 1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        check("jne.cnd", 64'(cnd), 64'd1);

        // addq max+max -> negative with overflow, then cmovge taken
        step("add_of", 0, 0, 1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF,
             64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        check("add_of.valE", val_e, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_of.sf", 64'(sf), 64'd1);
        step("cmovge", 0, 0, 1, 4'h2, 4'h5, 64'h42, 64'd7, 64'd0);
        check("cmovge.valE", val_e, 64'h42);
        check("cmovge.cnd", 64'(cnd), 64'd1);

        // push, stall holds everything, release accepts the held OPq
        step("push", 0, 0, 1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        check("push.valE", val_e, 64'hF8);
        step("stall", 0, 1, 1, 4'h6, 4'h3, 64'hFF, 64'hF0F0, 64'd0);
        check("stall.valE", val_e, 64'hF8);
        step("unstall", 0, 0, 1, 4'h6, 4'h3, 64'hFF, 64'hF0F0, 64'd0);
        check("unstall.valE", val_e, 64'hF00F);

        // Illegal function codes, then a bubble clears err
        step("opq_bad", 0, 0, 1, 4'h6, 4'h5, 64'd3, 64'd4, 64'd0);
        check("opq_bad.err", 64'(err), 64'd1);
        step("jxx_bad", 0, 0, 1, 4'h7, 4'h9, 64'd0, 64'd0, 64'd0);
        check("jxx_bad.err", 64'(err), 64'd1);
        step("bubble", 0, 0, 0, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0);
        check("bubble.err", 64'(err), 64'd0);
        check("bubble.valid", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 4) == 0);
            v = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0:       ic = 4'h6;
                1:       ic = 4'h7;
                2:       ic = 4'h2;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            fn = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6))
                                             : 4'($urandom_range(0, 15));
            step("rand", r, s, v, ic, fn, rand_operand(), rand_operand(), rand_operand());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_cc_stage.md
Name: execute_cc_stage

Overview:
Registered execute stage of the Y86-64 datapath. It sits directly downstream of decode/register-file read and upstream of the memory stage. It contains the 64-bit ALU (add, sub, and, xor), which reuses the team's 64-bit subtractor for subq. It also holds the architectural condition-code register (ZF/SF/OF) and evaluates the branch/cmov condition Cnd. All results are registered with a valid/stall handshake toward the memory stage.

Parameters:
WIDTH, 64, datapath width; only 64 is supported.
STACK_STEP, 8, signed stack-pointer adjustment magnitude for call/push/ret/pop.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  decoded instruction present this cycle
stall  input  1  downstream not ready; hold all state
icode  input  4  Y86 instruction code
ifun  input  4  Y86 function code
valA  input  64  rA operand
valB  input  64  rB operand
valC  input  64  immediate/displacement
out_valid  output  1  registered outputs hold an accepted instruction
valE  output  64  registered ALU result
cnd  output  1  registered condition result (jXX/cmovXX)
zf  output  1  condition code: zero
sf  output  1  condition code: sign
of  output  1  condition code: signed overflow
err  output  1  registered: illegal ifun for OPq/jXX/cmovXX

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst has priority over stall and in_valid.
- Reset values: out_valid=0, valE=0, cnd=0, err=0, zf=1, sf=0, of=0.
- Accept condition: rising edge with rst=0, stall=0 and in_valid=1. All outputs update at that edge, giving 1-cycle latency.
- Bubble: rst=0, stall=0 and in_valid=0. At the edge, out_valid=0, err=0 and cnd=0. valE and the CCs hold.
- Stall: rst=0 and stall=1. Every register holds, including out_valid and the CCs, regardless of in_valid.
- ALU operand select (aluA, aluB, function):
  - OPq (6): valA, valB, ifun.
  - rrmovq/cmovXX (2): valA, 0, add.
  - irmovq (3): valC, 0, add.
  - rmmovq (4) and mrmovq (5): valC, valB, add.
  - call (8) and push (A): -STACK_STEP, valB, add.
  - ret (9) and pop (B): +STACK_STEP, valB, add.
  - halt (0), nop (1), jXX (7) and undefined icodes: valE=0.
- ALU functions:
  - ifun 0 add: aluB+aluA.
  - ifun 1 sub: aluB-aluA, so subq rA,rB yields rB-rA.
  - ifun 2 and, ifun 3 xor: bitwise.
  - Result is modulo 2^64; no carry output.
- Overflow:
  - add: of = (aA[63]==aB[63]) && (r[63]!=aA[63]).
  - sub: of = (aB[63]!=aA[63]) && (r[63]!=aB[63]).
  - and, xor: of=0.
- CC update: only an accepted OPq with ifun<=3 updates the CCs, with zf=(r==0), sf=r[63] and of as above. All other instructions leave the CCs unchanged.
- Illegal OPq ifun (>3): valE=0, CCs unchanged, err=1.
- Condition evaluation uses the CC register value before the current edge. An OPq followed next cycle by jXX sees the OPq's flags. cmov/jXX ifun mapping:
  - 0 always: 1.
  - 1 le: (sf^of)|zf.
  - 2 l: sf^of.
  - 3 e: zf.
  - 4 ne: ~zf.
  - 5 ge: ~(sf^of).
  - 6 g: ~(sf^of)&~zf.
  - ifun>6: cnd=0, err=1.
- cnd is 0 for every icode other than 2 and 7. err is 0 for every legal instruction.
- Reset asserted while stalled or mid-stream discards the held instruction: out_valid=0 and the CCs return to their reset values.

Test Plan:
- Assert rst for 2 cycles with stall=1 and in_valid=1 -> out_valid=0, valE=0, zf=1, sf=0, of=0, cnd=0, err=0.
- OPq sub with valA=5, valB=5 -> next cycle out_valid=1, valE=0, zf=1, sf=0, of=0.
- OPq sub with valA=1, valB=0x8000000000000000 -> valE=0x7FFFFFFFFFFFFFFF, of=1, sf=0, zf=0. Then jXX ifun=2 (l) next cycle -> cnd=1. jXX ifun=4 (ne) -> cnd=1.
- OPq add with valA=valB=0x7FFFFFFFFFFFFFFF -> valE=0xFFFFFFFFFFFFFFFE, sf=1, of=1. Then cmovXX ifun=5 (ge) with valA=0x42 -> valE=0x42, cnd=1, CCs unchanged.
- push with valB=0x100 -> valE=0xF8, CCs unchanged. Next cycle stall=1 with new in_valid OPq -> all outputs and CCs hold. Release stall -> the OPq is accepted on the following edge.
- OPq ifun=5 -> err=1, valE=0, CCs unchanged. jXX ifun=9 -> cnd=0, err=1. Subsequent bubble -> out_valid=0, err=0.
